// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: state, opcode and opcode-class definitions for the multicycle step sequencer
package cpu_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_ILLEGAL} op_class_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: combinational opcode to instruction-class decode with illegal flag
module opcode_classifier
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class,
  output logic       illegal
);
  always_comb begin
    op_class = opcode == OP_RTYPE ? C_RTYPE :
               opcode == OP_ADDI  ? C_ADDI  :
               opcode == OP_LW    ? C_LW    :
               opcode == OP_SW    ? C_SW    :
               opcode == OP_BEQ   ? C_BEQ   :
               opcode == OP_J     ? C_J     : C_ILLEGAL;
    illegal = op_class == C_ILLEGAL;
  end
endmodule

// File: rtl/multicycle_step_sequencer.sv
// multicycle_step_sequencer: fetch/decode/exec/mem/wb control FSM with memory handshake and retire counter
module multicycle_step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             alu_en,
  output logic             wb_en,
  output logic             control_mux_for_write_back,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired_count,
  output logic             halted,
  output logic [2:0]       state
);
  state_t    state_q, state_n, after;
  op_class_t cls, cls_q;
  logic      illegal;
  opcode_classifier u_classifier (.opcode(opcode), .op_class(cls), .illegal(illegal));
  always_comb begin
    instr_done = (state_q == S_EXEC && (cls_q == C_BEQ || cls_q == C_J)) ||
                 (state_q == S_MEM && mem_ready && cls_q == C_SW) || state_q == S_WB;
    after = run ? S_FETCH : S_IDLE;
    case (state_q)
      S_IDLE:   state_n = after;
      S_FETCH:  state_n = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_n = illegal ? S_HALT : S_EXEC;
      S_EXEC:   state_n = instr_done ? after : (cls_q == C_LW || cls_q == C_SW) ? S_MEM : S_WB;
      S_MEM:    state_n = !mem_ready ? S_MEM : instr_done ? after : S_WB;
      S_WB:     state_n = after;
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cls_q         <= C_RTYPE;
      retired_count <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == S_DECODE) cls_q <= cls;
      if (instr_done) retired_count <= retired_count + CNT_W'(1);
    end
  end
  assign mem_req                    = state_q == S_FETCH || state_q == S_MEM;
  assign mem_write                  = state_q == S_MEM && cls_q == C_SW;
  assign ir_write                   = state_q == S_FETCH && mem_ready;
  assign pc_write                   = ir_write || (state_q == S_EXEC && cls_q == C_J);
  assign pc_write_cond              = state_q == S_EXEC && cls_q == C_BEQ;
  assign alu_en                     = state_q == S_EXEC;
  assign wb_en                      = state_q == S_WB;
  assign control_mux_for_write_back = state_q == S_WB && cls_q == C_LW;
  assign halted                     = state_q == S_HALT;
  assign state                      = state_q;
endmodule

// File: doc/multicycle_step_sequencer.md
# multicycle_step_sequencer

Central control FSM for the multicycle CPU. It walks each instruction through the fetch, decode, execute, memory and write-back steps, and skips the steps an opcode does not need. It stalls on a shared memory port through a ready handshake and drives the enables and selects that the step datapaths consume, including the write-back mux select. It sits between the instruction register and the per-step datapath blocks.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  permission to start new instructions.
- `opcode`  in  6  instruction-register opcode field; valid from the DECODE cycle on.
- `mem_ready`  in  1  memory port completed the current request this cycle.
- `mem_req`  out  1  memory request (instruction fetch or data access).
- `mem_write`  out  1  data store; meaningful only while `mem_req` is high.
- `ir_write`  out  1  load the instruction register.
- `pc_write`  out  1  unconditional PC update.
- `pc_write_cond`  out  1  PC update if the branch compare is true.
- `alu_en`  out  1  execute-step enable.
- `wb_en`  out  1  register-file write.
- `control_mux_for_write_back`  out  1  write-back select: 1 = memory data, 0 = ALU result.
- `instr_done`  out  1  one-cycle pulse on the final step of each instruction.
- `retired_count`  out  CNT_W  completed instructions.
- `halted`  out  1  illegal opcode trapped; sticky.
- `state`  out  3  current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Opcode classes:
  - R-type: 000000
  - addi: 001000
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - j: 000010
  - anything else is illegal.
- IDLE: all strobes low. Go to FETCH when `run`=1.
- FETCH: `mem_req`=1, `mem_write`=0. Hold until `mem_ready`. In the ready cycle, `ir_write`=1 and `pc_write`=1 (PC+4); next state is DECODE.
- DECODE: one cycle. Latch `opcode` into `opcode_q`. An illegal opcode goes to HALT; otherwise go to EXEC.
- EXEC: `alu_en`=1 for one cycle. Next step by class:
  - beq: `pc_write_cond`=1, instruction done.
  - j: `pc_write`=1, instruction done.
  - R-type, addi: go to WB.
  - lw, sw: go to MEM.
- MEM: `mem_req`=1, `mem_write` = (class is sw). Hold until `mem_ready`. Then lw goes to WB; sw is done in the ready cycle.
- WB: `wb_en`=1 for one cycle. `control_mux_for_write_back` = 1 for lw, 0 otherwise. Instruction done.
- Instruction done:
  - `instr_done` pulses in that cycle and `retired_count` increments, wrapping modulo 2^CNT_W.
  - Next state is FETCH if `run`=1, else IDLE.
- `run` dropping mid-instruction never aborts the instruction; it only blocks the next fetch.
- HALT: all strobes low and `halted`=1. Only `rst` leaves HALT; `run` is ignored.
- Every state after DECODE uses `opcode_q` only; IR changes after decode are ignored.
- `control_mux_for_write_back` is 0 in every state except WB with an lw.

## Timing
- State and `opcode_q` are registered. Strobes decode combinationally from state, `opcode_q` and `mem_ready`.
- Reset, taking effect at the next edge:
  - state = IDLE, `opcode_q` = 0, `retired_count` = 0, `halted` = 0.
  - Every strobe output is 0.
  - Reset wins over every other event, including reset asserted mid-instruction.
- Latency with `mem_ready` held high, cycles from entering FETCH to `instr_done`:
  - lw: 5
  - R-type, addi, sw: 4
  - beq, j: 3
- Each low-`mem_ready` cycle in FETCH or MEM adds exactly one cycle.
- Memory handshake:
  - `mem_req` stays high, with `mem_write` stable, from the first cycle of FETCH or MEM until the `mem_ready` cycle.
  - `mem_ready` while `mem_req`=0 is ignored.
- Back-to-back execution: with `run`=1, the next FETCH is in the cycle after `instr_done`. There are no bubbles.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum or localparams;
  - the six opcode constants;
  - the class encoding (RTYPE, ADDI, LW, SW, BEQ, J, ILLEGAL).
- One sub-module, `opcode_classifier`: combinational, 6-bit opcode in, class plus illegal flag out. It is instantiated once on `opcode`, and its result is registered at DECODE.
- The FSM, the strobe decode and the counter stay in the top module.

## Test plan
- lw (100011), `mem_ready`=1 throughout, `run`=1 → states FETCH, DECODE, EXEC, MEM, WB. `control_mux_for_write_back`=1 and `wb_en`=1 in the WB cycle only. `instr_done` in cycle 5. `retired_count`=1.
- sw (101011), `mem_ready` low for 3 MEM cycles → `mem_req`=1 and `mem_write`=1 held for 4 cycles. No `wb_en`. `instr_done` at cycle 7.
- Sequence beq, j, R-type, addi with `run`=1 → `instr_done` at cycles 3, 6, 10, 14. `pc_write_cond` only in the beq EXEC cycle. `retired_count`=4.
- Opcode 111111 → HALT after DECODE. `halted`=1, no further `mem_req` for 20 cycles with `run`=1. `rst` returns to IDLE with `halted`=0.
- `run` dropped in the EXEC cycle of an lw → lw completes, then the FSM goes to IDLE with no new fetch. `run` reasserted → FETCH next cycle.
- `rst` in the MEM cycle of an lw → next cycle is IDLE with all strobes 0 and the count unchanged-to-0. `retired_count` preset to all-ones followed by one retire → wraps to 0.
